uart_tx_arbiter: RTL and testbench

Shares the single UART transmit path (tx controller plus shift register) between N_REQ byte producers, e.g. core store port, debug monitor and trap printer. Round-robin arbitration with optional message lock, so a multi-byte string from one requester is never interleaved with another's.
Sequences the tx controller's byte_ready / t_byte inputs and waits for frame completion before granting again.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/rr_picker.sv | 41 ++++
 rtl/uart_tx_arbiter.sv | 162 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter and related blocks.
//
// Contents:
//   UART_DW        byte width of the transmit path
//   N_REQ_DEFAULT  default number of byte producers sharing the tx path
//   tx_state_e     arbiter sequencing states (IDLE, ARM, TRIG, BUSY)
package uart_pkg;

    localparam int UART_DW       = 8;
    localparam int N_REQ_DEFAULT = 4;

    // IDLE: arbitrate; ARM: present byte; TRIG: fire t_byte; BUSY: wait for frame end
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        TRIG = 2'd2,
        BUSY = 2'd3
    } tx_state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker.
//
// Scans the request vector starting one position above ptr and wrapping,
// returning the first set requester.
//
// Ports:
//   req        in   N   request vector
//   ptr        in   IW  last winner; the scan starts at (ptr+1) mod N
//   onehot     out  N   one-hot winner, 0 when nothing requests
//   idx        out  IW  winner index, 0 when nothing requests
//   any_valid  out  1   at least one request is set
module rr_picker #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          any_valid
);

    logic [IW-1:0] pos;

    always_comb begin
        onehot    = '0;
        idx       = '0;
        any_valid = 1'b0;
        pos       = '0;
        // Offset runs 1..N so the previous winner (ptr itself) is tried last.
        for (int i = 1; i <= N; i++) begin
            pos = IW'((int'(ptr) + i) % N);
            if (!any_valid && req[pos]) begin
                any_valid   = 1'b1;
                onehot[pos] = 1'b1;
                idx         = pos;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmit path between N_REQ byte
// producers, with an optional message lock so a multi-byte string from one
// requester is never interleaved with another's.
//
// Handshake: requester k holds req_valid_i[k], its byte and req_last_i[k]
// stable until req_ready_o[k] pulses for one cycle; that pulse is the accept.
// Dropping valid before the pulse withdraws the byte. req_last_i=0 on an
// accepted byte keeps the lock so only that requester is granted next.
//
// Ports:
//   clk_i         in   1        system clock
//   reset_i       in   1        asynchronous, active-high reset
//   req_valid_i   in   N_REQ    requester k has a byte
//   req_data_i    in   8*N_REQ  byte of requester k at [8k+7:8k]
//   req_last_i    in   N_REQ    byte ends the message (0 requests the lock)
//   req_ready_o   out  N_REQ    one-hot accept pulse
//   grant_o       out  N_REQ    one-hot current owner, 0 when none
//   tx_data_o     out  8        byte for the transmit data register
//   byte_ready_o  out  1        tx controller byte_ready (one cycle)
//   t_byte_o      out  1        tx controller t_byte (one cycle)
//   tx_done_i     in   1        stop bit finished (honoured only in BUSY)
//   busy_o        out  1        any state other than IDLE
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ   = N_REQ_DEFAULT,
    parameter int LOCK_TO = 1024
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [N_REQ-1:0]           req_valid_i,
    input  logic [UART_DW*N_REQ-1:0]   req_data_i,
    input  logic [N_REQ-1:0]           req_last_i,
    output logic [N_REQ-1:0]           req_ready_o,
    output logic [N_REQ-1:0]           grant_o,
    output logic [UART_DW-1:0]         tx_data_o,
    output logic                       byte_ready_o,
    output logic                       t_byte_o,
    input  logic                       tx_done_i,
    output logic                       busy_o
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = (LOCK_TO > 1) ? $clog2(LOCK_TO) : 1;

    tx_state_e          state_q, state_d;
    logic [IW-1:0]      rr_ptr_q;
    logic               lock_q;
    logic [CW-1:0]      lock_cnt_q;
    logic [N_REQ-1:0]   grant_q;
    logic [UART_DW-1:0] hold_q;

    logic [N_REQ-1:0]   cand_req;
    logic [N_REQ-1:0]   win_onehot;
    logic [IW-1:0]      win_idx;
    logic               win_any;
    logic               accept;
    logic               stall;
    logic               timeout;
    logic [UART_DW-1:0] sel_byte;
    logic               sel_last;

    // While locked the owner is the only candidate; grant_q is its one-hot mask.
    assign cand_req = lock_q ? (req_valid_i & grant_q) : req_valid_i;

    rr_picker #(
        .N  (N_REQ),
        .IW (IW)
    ) u_pick (
        .req       (cand_req),
        .ptr       (rr_ptr_q),
        .onehot    (win_onehot),
        .idx       (win_idx),
        .any_valid (win_any)
    );

    assign accept  = (state_q == IDLE) && win_any;
    // Locked owner not offering a byte while we are free to send.
    assign stall   = (state_q == IDLE) && lock_q && !win_any;
    assign timeout = stall && (lock_cnt_q == CW'(LOCK_TO - 1));

    always_comb begin
        sel_byte = '0;
        sel_last = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (win_onehot[k]) begin
                sel_byte = req_data_i[k*UART_DW +: UART_DW];
                sel_last = req_last_i[k];
            end
        end
    end

    // State register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and state-decoded outputs
    always_comb begin
        state_d      = state_q;
        byte_ready_o = 1'b0;
        t_byte_o     = 1'b0;
        busy_o       = 1'b1;
        case (state_q)
            IDLE: begin
                busy_o = 1'b0;
                if (accept) state_d = ARM;
            end
            ARM: begin
                byte_ready_o = 1'b1;
                state_d      = TRIG;
            end
            TRIG: begin
                t_byte_o = 1'b1;
                state_d  = BUSY;
            end
            BUSY: begin
                if (tx_done_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The accept pulse is combinational from req_valid_i; masking it with
    // reset_i keeps every output low while reset is held.
    assign req_ready_o = (accept && !reset_i) ? win_onehot : '0;
    assign grant_o     = grant_q;
    assign tx_data_o   = hold_q;

    // Ownership, lock and hold register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rr_ptr_q   <= IW'(N_REQ - 1);
            lock_q     <= 1'b0;
            lock_cnt_q <= '0;
            grant_q    <= '0;
            hold_q     <= '0;
        end else begin
            if (accept) begin
                hold_q     <= sel_byte;
                grant_q    <= win_onehot;
                rr_ptr_q   <= win_idx;
                lock_q     <= ~sel_last;
                lock_cnt_q <= '0;
            end else if (timeout) begin
                // rr_ptr_q still names the stalled owner, so it is tried last.
                lock_q     <= 1'b0;
                grant_q    <= '0;
                lock_cnt_q <= '0;
            end else if (stall) begin
                lock_cnt_q <= lock_cnt_q + 1'b1;
            end else if ((state_q == BUSY) && tx_done_i && !lock_q) begin
                grant_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

    localparam int N       = 4;
    localparam int LOCK_TO = 8;
    localparam int CAP     = 4096;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset_i;
    logic [N-1:0]   req_valid_i;
    logic [8*N-1:0] req_data_i;
    logic [N-1:0]   req_last_i;
    logic [N-1:0]   req_ready_o;
    logic [N-1:0]   grant_o;
    logic [7:0]     tx_data_o;
    logic           byte_ready_o;
    logic           t_byte_o;
    logic           tx_done_i;
    logic           busy_o;

    uart_tx_arbiter #(
        .N_REQ   (N),
        .LOCK_TO (LOCK_TO)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .req_valid_i  (req_valid_i),
        .req_data_i   (req_data_i),
        .req_last_i   (req_last_i),
        .req_ready_o  (req_ready_o),
        .grant_o      (grant_o),
        .tx_data_o    (tx_data_o),
        .byte_ready_o (byte_ready_o),
        .t_byte_o     (t_byte_o),
        .tx_done_i    (tx_done_i),
        .busy_o       (busy_o)
    );

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at t=%0t: got 0x%0h, expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    // ---------------- requester sources ----------------
    logic [8:0] src_mem [N][CAP];   // {last, data}
    int         src_rd [N];
    int         src_wr [N];
    bit         src_en [N];

    task automatic push(input int k, input logic [7:0] d, input bit last);
        if (src_wr[k] < CAP) begin
            src_mem[k][src_wr[k]] = {last, d};
            src_wr[k]++;
        end
    endtask

    // ---------------- reference model (message/arbitration level) ----------------
    // m_phase counts cycles since accept: 0 free, 1 byte offered, 2 triggered, 3 on air.
    int         m_phase, m_ptr, m_owner, m_stall, m_cand;
    bit         m_lock;
    logic [7:0] m_data;
    int         done_wait, done_dly;
    bit         done_rand, stray_en;
    int         cyc, done_cyc, gap0;
    bit         chk_first;
    logic [7:0] exp_q[$];
    logic [7:0] tx_log[$];

    function automatic void model_reset();
        m_phase = 0;
        m_ptr   = N - 1;
        m_owner = -1;
        m_stall = 0;
        m_lock  = 1'b0;
        m_data  = 8'h00;
        exp_q.delete();
    endfunction

    function automatic int model_pick();
        int c = -1;
        if (m_phase != 0) return -1;
        if (m_lock) begin
            if (m_owner >= 0 && req_valid_i[m_owner]) c = m_owner;
        end else begin
            for (int i = 1; i <= N; i++) begin
                int j = (m_ptr + i) % N;
                if (c < 0 && req_valid_i[j]) c = j;
            end
        end
        return c;
    endfunction

    task automatic model_update();
        case (m_phase)
            0: begin
                if (m_cand >= 0) begin
                    m_data  = src_mem[m_cand][src_rd[m_cand]][7:0];
                    m_lock  = !src_mem[m_cand][src_rd[m_cand]][8];
                    exp_q.push_back(m_data);
                    m_owner = m_cand;
                    m_ptr   = m_cand;
                    m_stall = 0;
                    src_rd[m_cand]++;
                    m_phase = 1;
                end else if (m_lock) begin
                    if (m_stall == LOCK_TO - 1) begin
                        m_lock  = 1'b0;
                        m_owner = -1;
                        m_stall = 0;
                    end else begin
                        m_stall++;
                    end
                end
            end
            1: m_phase = 2;
            2: begin
                m_phase   = 3;
                done_wait = done_rand ? int'($urandom_range(0, 6)) : done_dly;
            end
            default: begin
                if (tx_done_i) begin
                    m_phase  = 0;
                    done_cyc = cyc;
                    if (!m_lock) m_owner = -1;
                end
            end
        endcase
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_reqs();
        for (int k = 0; k < N; k++) begin
            bit v;
            v = src_en[k] && (src_rd[k] != src_wr[k]);
            req_valid_i[k] = v;
            if (v) begin
                req_data_i[8*k +: 8] = src_mem[k][src_rd[k]][7:0];
                req_last_i[k]        = src_mem[k][src_rd[k]][8];
            end else begin
                req_data_i[8*k +: 8] = 8'($urandom);
                req_last_i[k]        = 1'($urandom);
            end
        end
    endtask

    task automatic drive_done();
        tx_done_i = 1'b0;
        if (m_phase == 3) begin
            if (done_wait == 0) tx_done_i = 1'b1;
            else done_wait--;
        end else if (stray_en && $urandom_range(0, 2) == 0) begin
            tx_done_i = 1'b1;
        end
    endtask

    // One clock: compare at negedge, advance model at posedge, drive at posedge+1.
    task automatic step();
        logic [N-1:0] exp_ready;
        logic [N-1:0] exp_grant;
        @(negedge clk);
        m_cand    = model_pick();
        exp_ready = '0;
        exp_grant = '0;
        if (m_cand >= 0) exp_ready[m_cand] = 1'b1;
        if (m_owner >= 0) exp_grant[m_owner] = 1'b1;
        check("req_ready", 32'(req_ready_o), 32'(exp_ready));
        check("grant", 32'(grant_o), 32'(exp_grant));
        check("byte_ready", 32'(byte_ready_o), 32'(m_phase == 1));
        check("t_byte", 32'(t_byte_o), 32'(m_phase == 2));
        check("busy", 32'(busy_o), 32'(m_phase != 0));
        check("tx_data", 32'(tx_data_o), 32'(m_data));
        if (chk_first) begin
            check("first_accept", 32'(req_ready_o), 32'h1);
            chk_first = 1'b0;
        end
        if (byte_ready_o) begin
            tx_log.push_back(tx_data_o);
            check("sb_pending", 32'(exp_q.size() > 0), 32'h1);
            if (exp_q.size() > 0) check("sb_byte", 32'(tx_data_o), 32'(exp_q.pop_front()));
        end
        if (req_ready_o[0]) gap0 = cyc - done_cyc;
        @(posedge clk);
        model_update();
        cyc++;
        #1;
        drive_reqs();
        drive_done();
    endtask

    // Called at posedge+1: asserts reset between edges, checks outputs fall at once.
    task automatic do_reset();
        #2 reset_i = 1'b1;
        #1;
        check("rst_req_ready", 32'(req_ready_o), 32'h0);
        check("rst_grant", 32'(grant_o), 32'h0);
        check("rst_tx_data", 32'(tx_data_o), 32'h0);
        check("rst_byte_ready", 32'(byte_ready_o), 32'h0);
        check("rst_t_byte", 32'(t_byte_o), 32'h0);
        check("rst_busy", 32'(busy_o), 32'h0);
        model_reset();
        drive_reqs();
        drive_done();
        repeat (2) @(posedge clk);
        #1 reset_i = 1'b0;
    endtask

    function automatic bit drained();
        bit d = (m_phase == 0) && !m_lock;
        for (int k = 0; k < N; k++) if (src_rd[k] != src_wr[k]) d = 1'b0;
        return d;
    endfunction

    task automatic run_drain(input int maxc);
        int i = 0;
        while (!drained() && i < maxc) begin
            step();
            i++;
        end
        check("drain", 32'(drained()), 32'h1);
    endtask

    task automatic check_log(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3, input logic [7:0] e4,
                             input int len);
        logic [7:0] e [5];
        e = '{e0, e1, e2, e3, e4};
        check({tag, "_len"}, 32'(tx_log.size()), 32'(len));
        for (int i = 0; i < len; i++) begin
            check({tag, "_byte"}, (i < tx_log.size()) ? 32'(tx_log[i]) : 32'hFFFF, 32'(e[i]));
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        reset_i     = 1'b1;
        req_valid_i = '0;
        req_data_i  = '0;
        req_last_i  = '0;
        tx_done_i   = 1'b0;
        cyc = 0; done_cyc = 0; gap0 = -1;
        done_dly = 19; done_rand = 1'b0; stray_en = 1'b0; chk_first = 1'b0;
        for (int k = 0; k < N; k++) begin
            src_rd[k] = 0; src_wr[k] = 0; src_en[k] = 1'b1;
        end
        model_reset();
        repeat (3) @(posedge clk);
        #1 reset_i = 1'b0;
        repeat (3) step();

        // Rotation with all four valid, reset asserted mid-cycle while they are.
        push(0, 8'h41, 1'b1); push(1, 8'h42, 1'b1); push(2, 8'h43, 1'b1);
        push(3, 8'h44, 1'b1); push(0, 8'h41, 1'b1);
        drive_reqs();
        do_reset();
        chk_first = 1'b1;
        tx_log.delete();
        run_drain(600);
        check_log("rotation", 8'h41, 8'h42, 8'h43, 8'h44, 8'h41, 5);

        // Lock: req1 string of three while req0/req2 wait; stray done pulses outside BUSY.
        tx_log.delete();
        done_dly = 3;
        stray_en = 1'b1;
        push(1, 8'h51, 1'b0); push(1, 8'h52, 1'b0); push(1, 8'h53, 1'b1);
        push(0, 8'h60, 1'b1); push(2, 8'h70, 1'b1);
        drive_reqs();
        run_drain(400);
        check_log("lock", 8'h51, 8'h52, 8'h53, 8'h70, 8'h60, 5);

        // Lock timeout: req3 opens a message and goes quiet, req0 waits.
        tx_log.delete();
        stray_en = 1'b0;
        done_dly = 2;
        push(3, 8'h33, 1'b0); push(0, 8'h05, 1'b1);
        drive_reqs();
        run_drain(400);
        check_log("timeout", 8'h33, 8'h05, 8'h00, 8'h00, 8'h00, 2);
        check("timeout_gap", 32'(gap0), 32'(LOCK_TO + 1));

        // Reset while req2 holds the lock and its byte is on air.
        push(2, 8'h21, 1'b0); push(2, 8'h22, 1'b0); push(0, 8'h0A, 1'b1);
        drive_reqs();
        for (int i = 0; i < 100 && !(m_phase == 3 && m_owner == 2); i++) step();
        check("busy_reached", 32'(m_phase == 3 && m_owner == 2), 32'h1);
        do_reset();
        tx_log.delete();
        chk_first = 1'b1;
        run_drain(400);
        check_log("rst_busy", 8'h0A, 8'h22, 8'h00, 8'h00, 8'h00, 2);

        // Randomized traffic: random messages, valid drops, done delays, stray dones.
        done_rand = 1'b1;
        stray_en  = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < N; k++) begin
                src_en[k] = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 7) == 0) push(k, 8'($urandom), ($urandom_range(0, 3) != 0));
            end
            drive_reqs();
            step();
        end
        stray_en = 1'b0;
        for (int k = 0; k < N; k++) src_en[k] = 1'b1;
        drive_reqs();
        run_drain(6000);
        check("sb_empty", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
